reg4_rr_arbiter: RTL and testbench

Round-robin arbiter and write sequencer sharing one 4-bit register between NREQ requesters. Grants exclusive write ownership to one requester at a time and loads the owner's data on write-enable. Issues a write acknowledge and force-releases owners that exceed a hold limit. Sits between requester logic and the shared 4-bit state register; the register is implemented inside this block.

---
 rtl/reg4_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_reg4_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg4_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// A single owner at a time may load the register. Each accepted write is acknowledged
// with a one-cycle pulse. An owner that holds the grant for HOLD_MAX cycles is
// released by force.
module reg4_rr_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                    CLK,
    input  logic                    CLR_B,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         WE,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         ACK,
    output logic [WIDTH-1:0]        Q,
    output logic                    BUSY,
    output logic [2:0]              OWNER
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    int unsigned       scan;
    logic              hold_expired;
    logic              owner_req;
    logic              owner_we;

    assign hold_expired = (hold_q == HW'(HOLD_MAX));
    assign owner_req    = REQ[owner_q];
    assign owner_we     = WE[owner_q];

    // Search upward from the round-robin pointer, wrapping, for the first active request.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = int'(ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!pick_found && REQ[scan[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IW-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a grant ends on request drop or when the hold limit is reached.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pick_found) state_d = StGrant;
            StGrant:   if (!owner_req || hold_expired) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values for grant, acknowledge, register, hold count and pointer.
    always_comb begin
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = HW'(1);
                end
            end
            StGrant: begin
                if (owner_req) begin
                    // A write in the final forced-release cycle is still honoured.
                    if (owner_we) begin
                        q_d   = WDATA[int'(owner_q)*WIDTH +: WIDTH];
                        ack_d = NREQ'(1) << owner_q;
                    end
                    if (hold_expired) begin
                        gnt_d = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    gnt_d = '0;
                end
            end
            StRelease: begin
                // The previous owner becomes lowest priority.
                ptr_d = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    // Datapath registers; reset aborts any grant without an acknowledge.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign GNT   = gnt_q;
    assign ACK   = ack_q;
    assign Q     = q_q;
    assign BUSY  = |gnt_q;
    assign OWNER = 3'(owner_q);

endmodule

// File: tb/tb_reg4_rr_arbiter.sv
// Bench for reg4_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_reg4_rr_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 8;

    logic           CLK = 1'b0;
    logic           CLR_B;
    logic [N-1:0]   REQ;
    logic [N-1:0]   WE;
    logic [N*W-1:0] WDATA;
    logic [N-1:0]   GNT;
    logic [N-1:0]   ACK;
    logic [W-1:0]   Q;
    logic           BUSY;
    logic [2:0]     OWNER;

    reg4_rr_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (
        .CLK   (CLK),
        .CLR_B (CLR_B),
        .REQ   (REQ),
        .WE    (WE),
        .WDATA (WDATA),
        .GNT   (GNT),
        .ACK   (ACK),
        .Q     (Q),
        .BUSY  (BUSY),
        .OWNER (OWNER)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Model: owner < 0 means nobody holds the grant; rel marks the dead cycle.
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_next;
    bit         m_rel;
    logic [3:0] m_q;
    logic [3:0] m_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_held  = 0;
        m_next  = 0;
        m_rel   = 1'b0;
        m_q     = '0;
        m_ack   = '0;
    endtask

    // Applies the arbitration rules for one rising edge using the current inputs.
    task automatic model_edge();
        m_ack = '0;
        if (!CLR_B) begin
            model_reset();
        end else if (m_rel) begin
            m_rel  = 1'b0;
            m_next = (m_last + 1) % N;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && REQ[(m_next + k) % N]) begin
                    m_owner = (m_next + k) % N;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else if (!REQ[m_owner]) begin
            m_owner = -1;
            m_rel   = 1'b1;
        end else begin
            if (WE[m_owner]) begin
                m_q   = WDATA[m_owner*W +: W];
                m_ack = 4'(1 << m_owner);
            end
            if (m_held >= H) begin
                m_owner = -1;
                m_rel   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_gnt"}, 32'(GNT), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check({tag, "_ack"}, 32'(ACK), 32'(m_ack));
        check({tag, "_q"}, 32'(Q), 32'(m_q));
        check({tag, "_busy"}, 32'(BUSY), (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, "_owner"}, 32'(OWNER), 32'(m_last));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic wait_grant(input string tag);
        int guard;
        guard = 0;
        step(tag);
        while (GNT == '0 && guard < 12) begin
            step(tag);
            guard++;
        end
        check({tag, "_grant_seen"}, 32'(|GNT), 32'd1);
    endtask

    task automatic do_reset();
        CLR_B = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        step("rst_hold");
        step("rst_hold");
        CLR_B = 1'b1;
    endtask

    int cnt;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] rr_data [5] = '{4'b1011, 4'b0011, 4'b0100, 4'b1110, 4'b1011};

    initial begin
        CLR_B = 1'b0;
        REQ   = '0;
        WE    = '0;
        WDATA = '0;
        model_reset();
        #2;
        check_all("por");
        CLR_B = 1'b1;
        @(posedge CLK);
        #1;
        model_edge();
        check_all("idle");

        // Reset with no requests.
        do_reset();

        // Single write, then drop request.
        REQ = 4'b0001;
        step("sw_grant");
        check("sw_gnt", 32'(GNT), 32'b0001);
        WE = 4'b0001;
        WDATA = 16'h000E;
        step("sw_write");
        check("sw_q", 32'(Q), 32'b1110);
        check("sw_ack", 32'(ACK), 32'b0001);
        WE = '0;
        step("sw_ack_clear");
        check("sw_ack_pulse", 32'(ACK), 32'd0);
        REQ = '0;
        step("sw_release");
        check("sw_rel_gnt", 32'(GNT), 32'd0);
        step("sw_idle");

        // Round-robin order with all requesting.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            REQ = 4'b1111;
            wait_grant("rr");
            check("rr_owner", 32'(OWNER), 32'(order[g]));
            WE = 4'(1 << order[g]);
            WDATA = '0;
            WDATA[order[g]*W +: W] = rr_data[g];
            step("rr_write");
            check("rr_q", 32'(Q), 32'(rr_data[g]));
            WE = '0;
            REQ = 4'b1111 & ~4'(1 << order[g]);
            step("rr_drop");
        end

        // Non-owner write ignored.
        REQ = '0;
        do_reset();
        REQ = 4'b0100;
        wait_grant("no");
        WE = 4'b0001;
        WDATA = 16'h000F;
        step("no_foreign");
        check("no_q_kept", 32'(Q), 32'd0);
        check("no_ack", 32'(ACK), 32'd0);
        WE = 4'b0100;
        WDATA = 16'h0300;
        step("no_owner");
        check("no_q", 32'(Q), 32'b0011);
        check("no_ack_own", 32'(ACK), 32'b0100);
        WE = '0;

        // Forced release after HOLD_MAX cycles.
        REQ = '0;
        do_reset();
        REQ = 4'b0010;
        wait_grant("fr");
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step("fr_hold");
            if (GNT != 4'b0010) break;
            cnt++;
        end
        check("fr_len", 32'(cnt), 32'(H));
        wait_grant("fr_regrant");
        check("fr_regrant_gnt", 32'(GNT), 32'b0010);
        REQ = 4'b0011;
        for (int i = 0; i < 20 && GNT != '0; i++) step("fr_hold2");
        wait_grant("fr_next");
        check("fr_next_gnt", 32'(GNT), 32'b0001);

        // Reset in the middle of a grant with a write pending.
        REQ = '0;
        do_reset();
        REQ = 4'b1000;
        wait_grant("rm");
        WE = 4'b1000;
        WDATA = 16'h5000;
        #2;
        CLR_B = 1'b0;
        model_reset();
        #1;
        check_all("rm_async");
        check("rm_gnt", 32'(GNT), 32'd0);
        step("rm_held");
        check("rm_q", 32'(Q), 32'd0);
        check("rm_ack", 32'(ACK), 32'd0);
        WE = '0;
        CLR_B = 1'b1;
        wait_grant("rm_regrant");
        check("rm_regrant_gnt", 32'(GNT), 32'b1000);

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) REQ = N'($urandom);
            WE = N'($urandom);
            WDATA = (N*W)'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                CLR_B = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                #1;
                CLR_B = 1'b1;
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
